eth_miim_sequencer: RTL and testbench
=====================================

// Module: eth_miim_sequencer
// PURPOSE
//   MII management frame sequencer feeding eth_outputcontrol. On a Start request it runs one
//   Clause-22 MDIO frame (optional 32-bit preamble, ST/OP/PHYAD/REGAD/TA/DATA), stepping
//   BitCounter and ShiftedBit on each MdcEn_n pulse. For read operations it samples Mdi and
//   returns 16-bit read data. Sits between the host register interface and eth_outputcontrol.
// PARAMETERS
//   Tp       1   register assignment delay (#Tp), simulation only
//   RD_LAT   2   MdcEn_n events between BitCounter value and that bit reaching the Mdo pin
// PORTS
//   Clk         in   1   host clock; the only clock
//   Reset       in   1   reset, synchronous and active-high
//   MdcEn_n     in   1   1-Clk pulse before Mdc falls (advance strobe)
//   MdcEn       in   1   1-Clk pulse before Mdc rises (Mdi sample strobe)
//   Start       in   1   1-Clk request; accepted only when Busy=0
//   WriteOpIn   in   1   1=write frame, 0=read frame; latched on accept
//   NoPre       in   1   1=skip preamble; latched on accept
//   PhyAddr     in   5   PHY address; latched on accept
//   RegAddr     in   5   register address; latched on accept
//   WrData      in  16   write data; latched on accept
//   Mdi         in   1   MDIO input from pad
//   Busy        out  1   high from accept until Done
//   InProgress  out  1   frame bits being issued (to eth_outputcontrol)
//   WriteOp     out  1   latched op type (to eth_outputcontrol)
//   BitCounter  out  7   frame bit index 0..63 (to eth_outputcontrol)
//   ShiftedBit  out  1   serial frame data (to eth_outputcontrol)
//   RdData      out 16   read result; held until next read completes
//   Done        out  1   1-Clk completion pulse
// BEHAVIOUR
//   Reset: state=IDLE; Busy, InProgress, WriteOp, ShiftedBit, Done=0; BitCounter=0; RdData=0.
//   Reset asserted mid-frame aborts at once to reset values; no Done, RdData unchanged=0.
//   Frame word F[31:0] = {2'b01, op, PhyAddr, RegAddr, ta, WrData}; op=01 write/10 read;
//     ta=10 write, 00 read (pad released by eth_outputcontrol); read DATA field ignored.
//   States: IDLE -> RUN -> DRAIN -> IDLE.
//   IDLE: Start=1 -> latch inputs, Busy=1, InProgress=1, BitCounter = NoPre ? 32 : 0,
//     state=RUN on next Clk (no MdcEn_n wait). Start while Busy=1 ignored, no queueing.
//   RUN, each MdcEn_n: ShiftedBit <= (BitCounter>=32) ? F[63-BitCounter] : 0 (one event lag,
//     matches eth_outputcontrol pipeline); if BitCounter==63 -> InProgress=0, state=DRAIN,
//     BitCounter held at 63; else BitCounter+1. Between MdcEn_n pulses all outputs hold.
//   Delay line: RD_LAT-stage copy of BitCounter+valid, shifted on MdcEn_n, models pin timing.
//   Read capture: on MdcEn with WriteOp=0 and delayed count c in 48..63 valid:
//     shadow[63-c] <= Mdi. Write frames never touch shadow/RdData.
//   DRAIN: count RD_LAT+1 MdcEn_n events (ShiftedBit=0); then RdData<=shadow (reads only),
//     Done=1 for one Clk, Busy=0, BitCounter=0, state=IDLE. Start in Done cycle ignored.
//   Frame length: 64 (or 32 with NoPre) MdcEn_n events in RUN + RD_LAT+1 in DRAIN.
//   MdcEn and MdcEn_n in same Clk: illegal (bench assertion); design applies advance and
//     samples with pre-advance delayed count.
//   BitCounter never exceeds 63; no wrap. ShiftedBit=0 whenever InProgress=0.
// TESTING
//   Write, NoPre=0, Phy=01, Reg=04, WrData=A5C3 -> BitCounter 0..63, ShiftedBit after 32
//     seq 0101_00001_00100_10_1010010111000011, Done after 64+3 MdcEn_n events.
//   Read, NoPre=1, Phy=1F, Reg=01, Mdi driven 0x796D aligned to RD_LAT -> BitCounter starts 32,
//     Done after 32+3 events, RdData=796D; second read Mdi=0 -> RdData=0000.
//   Start pulsed while Busy -> ignored; first frame's bits and Done unchanged, one Done only.
//   Reset at BitCounter=40 of read -> next Clk all outputs 0, BitCounter=0, no Done;
//     fresh Start completes normally.
//   MdcEn_n idle 100 Clks mid-frame -> BitCounter/ShiftedBit/InProgress frozen, resume exact.
//   Write after read -> RdData keeps previous read value; WriteOp=1 throughout frame.

Source files
------------

// File: rtl/eth_miim_sequencer.sv
// eth_miim_sequencer
// Runs one Clause-22 MDIO management frame per accepted Start request and
// feeds BitCounter/ShiftedBit/InProgress/WriteOp to eth_outputcontrol.
// BitCounter advances on MdcEn_n. Mdi is sampled on MdcEn through a short
// delay line that models when each counted bit actually reaches the pin.
//
// Handshake: Start is a one-Clk request. It is taken only while Busy=0 and
// Done=0. Busy stays high from the accepting edge until the edge that
// raises Done. Done is high for exactly one Clk. Requests that are not
// taken are dropped, never queued.
module eth_miim_sequencer #(
  parameter int RD_LAT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MdcEn_n,
  input  logic        MdcEn,
  input  logic        Start,
  input  logic        WriteOpIn,
  input  logic        NoPre,
  input  logic [4:0]  PhyAddr,
  input  logic [4:0]  RegAddr,
  input  logic [15:0] WrData,
  input  logic        Mdi,
  output logic        Busy,
  output logic        InProgress,
  output logic        WriteOp,
  output logic [6:0]  BitCounter,
  output logic        ShiftedBit,
  output logic [15:0] RdData,
  output logic        Done,
  output logic [1:0]  DbgState
);

  localparam int DW = $clog2(RD_LAT + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_inprog, w_inprog_nxt;
  logic          r_wop, w_wop_nxt;
  logic [31:0]   r_frame, w_frame_nxt;
  logic [6:0]    r_bc, w_bc_nxt;
  logic          r_sbit, w_sbit_nxt;
  logic [15:0]   r_rddata, w_rddata_nxt;
  logic          r_done, w_done_nxt;
  logic [DW-1:0] r_drain, w_drain_nxt;
  logic [15:0]   r_shadow;

  // Pin-timing delay line: counter value plus "bit is a frame bit" flag
  logic [6:0]    r_dly_cnt [RD_LAT];
  logic          r_dly_vld [RD_LAT];

  logic [4:0]    w_bit_idx;
  logic [6:0]    w_dly_c;
  logic          w_cap_en;

  // Frame word is indexed from the top: BitCounter 32 -> F[31], 63 -> F[0]
  assign w_bit_idx = 5'd31 - r_bc[4:0];

  // Read data field occupies delayed counts 48..63 -> shadow[15..0]
  assign w_dly_c  = r_dly_cnt[RD_LAT-1];
  assign w_cap_en = MdcEn && !r_wop && r_dly_vld[RD_LAT-1] &&
                    (w_dly_c[6:4] == 3'b011);

  // State register and all FSM-owned outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_inprog <= 1'b0;
      r_wop    <= 1'b0;
      r_frame  <= '0;
      r_bc     <= '0;
      r_sbit   <= 1'b0;
      r_rddata <= '0;
      r_done   <= 1'b0;
      r_drain  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_busy   <= w_busy_nxt;
      r_inprog <= w_inprog_nxt;
      r_wop    <= w_wop_nxt;
      r_frame  <= w_frame_nxt;
      r_bc     <= w_bc_nxt;
      r_sbit   <= w_sbit_nxt;
      r_rddata <= w_rddata_nxt;
      r_done   <= w_done_nxt;
      r_drain  <= w_drain_nxt;
    end
  end

  // Next-state logic: accept, step on MdcEn_n, drain the pin pipeline, finish
  always_comb begin
    w_state_nxt  = r_state;
    w_busy_nxt   = r_busy;
    w_inprog_nxt = r_inprog;
    w_wop_nxt    = r_wop;
    w_frame_nxt  = r_frame;
    w_bc_nxt     = r_bc;
    w_sbit_nxt   = r_sbit;
    w_rddata_nxt = r_rddata;
    w_done_nxt   = 1'b0;
    w_drain_nxt  = r_drain;
    unique case (r_state)
      S_IDLE: begin
        // The Done cycle still counts as busy for request purposes
        if (Start && !r_done) begin
          w_state_nxt  = S_RUN;
          w_busy_nxt   = 1'b1;
          w_inprog_nxt = 1'b1;
          w_wop_nxt    = WriteOpIn;
          w_frame_nxt  = {2'b01, (WriteOpIn ? 2'b01 : 2'b10), PhyAddr, RegAddr,
                          (WriteOpIn ? 2'b10 : 2'b00), WrData};
          w_bc_nxt     = NoPre ? 7'd32 : 7'd0;
          w_sbit_nxt   = 1'b0;
          w_drain_nxt  = '0;
        end
      end
      S_RUN: begin
        if (MdcEn_n) begin
          // Bit shown lags the counter by one event to match the output stage
          w_sbit_nxt = r_bc[5] ? r_frame[w_bit_idx] : 1'b0;
          if (r_bc == 7'd63) begin
            w_inprog_nxt = 1'b0;
            w_state_nxt  = S_DRAIN;
          end else begin
            w_bc_nxt = r_bc + 7'd1;
          end
        end
      end
      S_DRAIN: begin
        if (MdcEn_n) begin
          w_sbit_nxt = 1'b0;
          if (r_drain == DW'(RD_LAT)) begin
            if (!r_wop) w_rddata_nxt = r_shadow;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_bc_nxt    = 7'd0;
            w_state_nxt = S_IDLE;
          end else begin
            w_drain_nxt = r_drain + DW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Delay line: shifts on each advance while a frame is active
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_dly_cnt[i] <= '0;
        r_dly_vld[i] <= 1'b0;
      end
    end else if (MdcEn_n && (r_state != S_IDLE)) begin
      r_dly_cnt[0] <= r_bc;
      r_dly_vld[0] <= (r_state == S_RUN);
      for (int i = 1; i < RD_LAT; i++) begin
        r_dly_cnt[i] <= r_dly_cnt[i-1];
        r_dly_vld[i] <= r_dly_vld[i-1];
      end
    end
  end

  // Read shadow: Mdi sampled against the pre-advance delayed count
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_shadow <= '0;
    end else if (w_cap_en) begin
      r_shadow[~w_dly_c[3:0]] <= Mdi;
    end
  end

  assign Busy       = r_busy;
  assign InProgress = r_inprog;
  assign WriteOp    = r_wop;
  assign BitCounter = r_bc;
  assign ShiftedBit = r_sbit;
  assign RdData     = r_rddata;
  assign Done       = r_done;
  assign DbgState   = r_state;

endmodule

// File: tb/tb_eth_miim_sequencer.sv
// Testbench for eth_miim_sequencer: randomized frames checked against a
// frame-level model (frame word, event counts, pin-aligned Mdi data).
module tb_eth_miim_sequencer;

  localparam int RD_LAT = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MdcEn_n, MdcEn, Start, WriteOpIn, NoPre, Mdi;
  logic [4:0]  PhyAddr, RegAddr;
  logic [15:0] WrData;
  logic        Busy, InProgress, WriteOp, ShiftedBit, Done;
  logic [6:0]  BitCounter;
  logic [15:0] RdData;
  logic [1:0]  DbgState;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  logic [15:0] rd_model = '0;

  eth_miim_sequencer #(.RD_LAT(RD_LAT)) dut (
    .Clk(Clk), .Reset(Reset), .MdcEn_n(MdcEn_n), .MdcEn(MdcEn),
    .Start(Start), .WriteOpIn(WriteOpIn), .NoPre(NoPre),
    .PhyAddr(PhyAddr), .RegAddr(RegAddr), .WrData(WrData), .Mdi(Mdi),
    .Busy(Busy), .InProgress(InProgress), .WriteOp(WriteOp),
    .BitCounter(BitCounter), .ShiftedBit(ShiftedBit), .RdData(RdData),
    .Done(Done), .DbgState(DbgState)
  );

  // Clock
  always #5 Clk = ~Clk;

  // Done pulse monitor
  always @(negedge Clk) if (Done === 1'b1) n_done++;

  // Strobes must never coincide
  always @(posedge Clk)
    assert (!(MdcEn === 1'b1 && MdcEn_n === 1'b1))
      else $error("FAIL strobe_overlap both strobes high");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  task automatic scramble_inputs();
    WriteOpIn = 1'($urandom_range(0, 1));
    NoPre     = 1'($urandom_range(0, 1));
    PhyAddr   = 5'($urandom);
    RegAddr   = 5'($urandom);
    WrData    = 16'($urandom);
  endtask

  task automatic pulse_adv();
    MdcEn_n = 1'b1;
    @(posedge Clk); #1;
    MdcEn_n = 1'b0;
  endtask

  // One frame: model computes frame word, expected counter/bit per event,
  // pin-aligned read data and the event on which Done must appear.
  task automatic run_frame(input logic wop, input logic nopre, input logic [4:0] phy,
                           input logic [4:0] rga, input logic [15:0] wd,
                           input logic [15:0] rd_val, input int start_at,
                           input int stall_at, input int abort_at);
    logic [31:0] f, seen;
    logic [6:0]  exp_bc;
    logic        exp_sb, exp_ip;
    int          s, n_run, n_tot, pre, k, done0;
    f     = {2'b01, (wop ? 2'b01 : 2'b10), phy, rga, (wop ? 2'b10 : 2'b00), wd};
    s     = nopre ? 32 : 0;
    n_run = 64 - s;
    n_tot = n_run + RD_LAT + 1;
    seen  = '0;
    done0 = n_done;
    WriteOpIn = wop; NoPre = nopre; PhyAddr = phy; RegAddr = rga; WrData = wd;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    scramble_inputs();
    check("acc_busy", Busy, 1);
    check("acc_ip", InProgress, 1);
    check("acc_bc", BitCounter, s);
    check("acc_wop", WriteOp, wop);
    check("acc_sbit", ShiftedBit, 0);
    for (int e = 1; e <= n_tot; e++) begin
      pulse_adv();
      pre = s + e - 1;
      if (e <= n_run) begin
        exp_bc = (pre == 63) ? 7'd63 : 7'(pre + 1);
        exp_sb = (pre >= 32) ? f[63 - pre] : 1'b0;
        exp_ip = (pre != 63);
        if (pre >= 32) seen[63 - pre] = ShiftedBit;
      end else if (e < n_tot) begin
        exp_bc = 7'd63; exp_sb = 1'b0; exp_ip = 1'b0;
      end else begin
        exp_bc = 7'd0; exp_sb = 1'b0; exp_ip = 1'b0;
      end
      check("bc", BitCounter, exp_bc);
      check("sbit", ShiftedBit, exp_sb);
      check("ip", InProgress, exp_ip);
      check("busy", Busy, (e != n_tot));
      check("done", Done, (e == n_tot));
      check("wop", WriteOp, wop);
      if (e == abort_at) begin
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        rd_model = '0;
        check("abort_busy", Busy, 0);
        check("abort_ip", InProgress, 0);
        check("abort_wop", WriteOp, 0);
        check("abort_bc", BitCounter, 0);
        check("abort_sbit", ShiftedBit, 0);
        check("abort_rd", RdData, 0);
        check("abort_state", DbgState, 0);
        repeat (4) begin
          pulse_adv();
          idle(1);
        end
        check("abort_nodone", n_done, done0);
        check("abort_idle_bc", BitCounter, 0);
        return;
      end
      if (e == start_at) begin
        scramble_inputs();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("busy_start_bc", BitCounter, exp_bc);
        check("busy_start_wop", WriteOp, wop);
      end
      if (e == stall_at) begin
        idle(100);
        check("stall_bc", BitCounter, exp_bc);
        check("stall_sbit", ShiftedBit, exp_sb);
        check("stall_ip", InProgress, exp_ip);
      end
      if (e == n_tot) begin
        // Request during the Done cycle must be dropped
        scramble_inputs();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("donecyc_busy", Busy, 0);
        check("donecyc_done", Done, 0);
        check("donecyc_bc", BitCounter, 0);
      end else begin
        idle($urandom_range(0, 2));
        k = s + e - RD_LAT;
        Mdi = (!wop && k >= 48 && k <= 63) ? rd_val[63 - k] : 1'($urandom_range(0, 1));
        MdcEn = 1'b1;
        @(posedge Clk); #1;
        MdcEn = 1'b0;
        Mdi = 1'($urandom_range(0, 1));
        idle($urandom_range(0, 2));
      end
    end
    if (!wop) rd_model = rd_val;
    check("frame_bits", seen, f);
    check("rddata", RdData, rd_model);
    check("done_count", n_done, done0 + 1);
  endtask

  initial begin
    Reset = 1'b1; MdcEn_n = 1'b0; MdcEn = 1'b0; Start = 1'b0; Mdi = 1'b0;
    WriteOpIn = 1'b0; NoPre = 1'b0; PhyAddr = '0; RegAddr = '0; WrData = '0;
    idle(3);
    Reset = 1'b0;
    idle(1);
    check("rst_busy", Busy, 0);
    check("rst_ip", InProgress, 0);
    check("rst_wop", WriteOp, 0);
    check("rst_bc", BitCounter, 0);
    check("rst_sbit", ShiftedBit, 0);
    check("rst_rd", RdData, 0);
    check("rst_done", Done, 0);
    check("rst_state", DbgState, 0);

    // Directed write with preamble; exact 32-bit serial word
    run_frame(1'b1, 1'b0, 5'h01, 5'h04, 16'hA5C3, 16'h0000, -1, -1, -1);
    check("write_seq", {2'b01, 2'b01, 5'h01, 5'h04, 2'b10, 16'hA5C3},
          32'b0101_00001_00100_10_1010010111000011);
    // Directed read without preamble
    run_frame(1'b0, 1'b1, 5'h1F, 5'h01, 16'h1234, 16'h796D, -1, -1, -1);
    // Reset at BitCounter=40 of a read, then a fresh read
    run_frame(1'b0, 1'b1, 5'h03, 5'h02, 16'h0000, 16'hFFFF, -1, -1, 8);
    run_frame(1'b0, 1'b1, 5'h03, 5'h02, 16'h0000, 16'hB00C, -1, -1, -1);
    // Read returning zero
    run_frame(1'b0, 1'b1, 5'h1F, 5'h01, 16'h0000, 16'h0000, -1, -1, -1);
    // Long MdcEn_n gap mid-frame
    run_frame(1'b0, 1'b0, 5'h05, 5'h11, 16'h0000, 16'h3C5A, -1, 40, -1);
    // Write after read: RdData keeps the read value; Start while busy
    run_frame(1'b1, 1'b0, 5'h0A, 5'h1C, 16'h5AA5, 16'h0000, 10, -1, -1);
    run_frame(1'b1, 1'b1, 5'h15, 5'h07, 16'hC001, 16'h0000, 45, -1, -1);
    // Randomized frames
    for (int i = 0; i < 6; i++) begin
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom),
                $urandom_range(1, 30), (i == 2) ? 20 : -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
